// File: rtl/my_uart_rx.sv
// 8E1 UART receiver: start, 8 data bits LSB first, even parity, stop.
// Define UART_RX_PARITY_EN for the 11-bit parity frame; leave it undefined for plain 8N1.
module my_uart_rx #(
    parameter int CLK_FREQ  = 125_000_000,
    parameter int BAUD_RATE = 115_200
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RXD,
    output logic [7:0] Dout,
    output logic       Valid,
    output logic       Parity_err,
    output logic       Frame_err,
    output logic       Busy,
    output logic       LED_IDLE,
    output logic       LED_RX,
    output logic       LED_ERR
);

    localparam int BIT_CYC  = CLK_FREQ / BAUD_RATE;
    localparam int HALF_CYC = BIT_CYC / 2;
    localparam logic [10:0] BIT_LAST  = 11'(BIT_CYC - 1);
    localparam logic [10:0] HALF_LAST = 11'(HALF_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_e;

    state_e      state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    logic [2:0]  bitIdx_q, bitIdx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  dout_q, dout_d;
    logic        valid_q, valid_d;
    logic        frameErr_q, frameErr_d;
    logic        rxMeta_q, rxSync_q, rxPrev_q;
    logic        startEdge;
    logic        bitDone;
`ifdef UART_RX_PARITY_EN
    logic        err_q, err_d;
    logic        parityErr_q, parityErr_d;
`endif

    // Synchronizer flops reset high so an idle line never looks like a start edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rxMeta_q <= 1'b1;
            rxSync_q <= 1'b1;
            rxPrev_q <= 1'b1;
        end else begin
            rxMeta_q <= RXD;
            rxSync_q <= rxMeta_q;
            rxPrev_q <= rxSync_q;
        end
    end

    assign startEdge = rxPrev_q & ~rxSync_q;
    assign bitDone   = (cnt_q == BIT_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bitIdx_q   <= '0;
            shift_q    <= '0;
            dout_q     <= '0;
            valid_q    <= 1'b0;
            frameErr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            err_q       <= 1'b0;
            parityErr_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bitIdx_q   <= bitIdx_d;
            shift_q    <= shift_d;
            dout_q     <= dout_d;
            valid_q    <= valid_d;
            frameErr_q <= frameErr_d;
`ifdef UART_RX_PARITY_EN
            err_q       <= err_d;
            parityErr_q <= parityErr_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bitIdx_d   = bitIdx_q;
        shift_d    = shift_q;
        dout_d     = dout_q;
        valid_d    = 1'b0;
        frameErr_d = frameErr_q;
`ifdef UART_RX_PARITY_EN
        err_d       = err_q;
        parityErr_d = parityErr_q;
`endif

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (startEdge) begin
                    state_d = START;
                end
            end

            // A start bit that is high again at mid-bit was a glitch.
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (!rxSync_q) begin
                        state_d  = DATA;
                        bitIdx_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end

            DATA: begin
                if (bitDone) begin
                    cnt_d    = '0;
                    shift_d  = {rxSync_q, shift_q[7:1]};
                    bitIdx_d = bitIdx_q + 3'd1;
                    if (bitIdx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bitDone) begin
                    cnt_d   = '0;
                    err_d   = (^shift_q) ^ rxSync_q;
                    state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
`endif

            // Bytes with bad parity are still delivered; only a bad stop bit withholds them.
            STOP: begin
                if (bitDone) begin
                    cnt_d   = '0;
                    state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                    parityErr_d = err_q;
`endif
                    if (rxSync_q) begin
                        dout_d     = shift_q;
                        valid_d    = 1'b1;
                        frameErr_d = 1'b0;
                    end else begin
                        frameErr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign Dout      = dout_q;
    assign Valid     = valid_q;
    assign Frame_err = frameErr_q;
`ifdef UART_RX_PARITY_EN
    assign Parity_err = parityErr_q;
`else
    assign Parity_err = 1'b0;
`endif
    assign Busy      = (state_q != IDLE);
    assign LED_IDLE  = (state_q == IDLE);
    assign LED_RX    = Busy;
    assign LED_ERR   = Parity_err | Frame_err;

endmodule

// File: tb/tb_my_uart_rx.sv
// Scoreboard bench for my_uart_rx; adapts frame length to UART_RX_PARITY_EN.
module tb_my_uart_rx;

    localparam int CLK_FREQ = 125_000_000;
    localparam int BAUD     = 1_000_000;
    localparam int BIT_CYC  = CLK_FREQ / BAUD;
    localparam int HALF_CYC = BIT_CYC / 2;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int EXP_LAT = 2 + HALF_CYC + (FRAME_BITS - 1) * BIT_CYC + 1;

    logic       CLK;
    logic       RST;
    logic       RXD;
    logic [7:0] Dout;
    logic       Valid;
    logic       Parity_err;
    logic       Frame_err;
    logic       Busy;
    logic       LED_IDLE;
    logic       LED_RX;
    logic       LED_ERR;

    typedef struct {
        logic [7:0] data;
        logic       perr;
    } expect_t;

    expect_t sbQ[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int startCyc = 0;
    int validCount = 0;
    int pushCount = 0;
    int lastValidCyc = 0;
    int prevValidCyc = 0;

    my_uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD_RATE(BAUD)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .RXD       (RXD),
        .Dout      (Dout),
        .Valid     (Valid),
        .Parity_err(Parity_err),
        .Frame_err (Frame_err),
        .Busy      (Busy),
        .LED_IDLE  (LED_IDLE),
        .LED_RX    (LED_RX),
        .LED_ERR   (LED_ERR)
    );

    initial begin
        CLK = 1'b0;
        forever #4 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, obs, exp);
        end
    endtask

    // Every Valid pulse must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (Valid === 1'b1) begin
            validCount++;
            prevValidCyc = lastValidCyc;
            lastValidCyc = cyc;
            if (sbQ.size() == 0) begin
                checkOutput("unexpectedValid", 32'(Dout), 32'hFFFF_FFFF);
            end else begin
                expect_t e;
                e = sbQ.pop_front();
                checkOutput("dout", 32'(Dout), 32'(e.data));
                checkOutput("parityErr", 32'(Parity_err), 32'(e.perr));
                checkOutput("frameErr", 32'(Frame_err), 32'd0);
                checkOutput("ledErr", 32'(LED_ERR), 32'(e.perr));
            end
        end
    end

    task automatic driveBit(input logic v);
        RXD = v;
        repeat (BIT_CYC) @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic parFlip,
                                 input logic stopBit, input int idleBits);
        expect_t e;
        if (stopBit) begin
            e.data = data;
            e.perr = parFlip;
            sbQ.push_back(e);
            pushCount++;
        end
        startCyc = cyc;
        driveBit(1'b0);
        for (int i = 0; i < 8; i++) driveBit(data[i]);
`ifdef UART_RX_PARITY_EN
        driveBit((^data) ^ parFlip);
`endif
        driveBit(stopBit);
        for (int i = 0; i < idleBits; i++) driveBit(1'b1);
    endtask

    task automatic checkLatency(input string tag, input int obs, input int exp);
        checkOutput(tag, 32'((obs >= exp - 1 && obs <= exp + 1) ? exp : obs), 32'(exp));
    endtask

    initial begin
        #(8 * 200_000);
        $display("[TB] FAIL watchdog: got timeout, wanted completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int vc;
        RST = 1'b1;
        RXD = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;
        checkOutput("rstDout", 32'(Dout), 32'h00);
        checkOutput("rstValid", 32'(Valid), 32'd0);
        checkOutput("rstBusy", 32'(Busy), 32'd0);
        checkOutput("rstFlags", 32'({Parity_err, Frame_err}), 32'd0);
        checkOutput("rstLeds", 32'({LED_IDLE, LED_RX, LED_ERR}), 32'b100);
        repeat (5) @(posedge CLK);
        #1;

        fork
            applyStimulus(8'h41, 1'b0, 1'b1, 2);
            begin
                repeat (5 * BIT_CYC) @(posedge CLK);
                #2;
                checkOutput("midBusy", 32'({Busy, LED_RX, LED_IDLE}), 32'b110);
            end
        join
        checkLatency("latency", lastValidCyc - startCyc, EXP_LAT);
        checkOutput("idleBusy", 32'(Busy), 32'd0);

`ifdef UART_RX_PARITY_EN
        applyStimulus(8'h41, 1'b1, 1'b1, 2);
        checkOutput("perrHeld", 32'(Parity_err), 32'd1);
        checkOutput("perrLed", 32'(LED_ERR), 32'd1);
`endif

        vc = validCount;
        applyStimulus(8'h4F, 1'b0, 1'b0, 2);
        checkOutput("ferrNoValid", 32'(validCount), 32'(vc));
        checkOutput("ferrFlag", 32'(Frame_err), 32'd1);
        checkOutput("ferrParity", 32'(Parity_err), 32'd0);
        checkOutput("ferrDoutHeld", 32'(Dout), 32'h41);
        checkOutput("ferrLed", 32'(LED_ERR), 32'd1);

        applyStimulus(8'h42, 1'b0, 1'b1, 2);
        checkOutput("cleanFlags", 32'({Parity_err, Frame_err, LED_ERR}), 32'd0);

        // Low pulse shorter than half a bit must be rejected in START.
        vc = validCount;
        RXD = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        checkOutput("glitchBusy", 32'(Busy), 32'd1);
        repeat (HALF_CYC - 30) @(posedge CLK);
        #1;
        RXD = 1'b1;
        repeat (BIT_CYC) @(posedge CLK);
        #1;
        checkOutput("glitchIdle", 32'(Busy), 32'd0);
        checkOutput("glitchNoValid", 32'(validCount), 32'(vc));
        checkOutput("glitchState", 32'({Dout, Parity_err, Frame_err}), 32'({8'h42, 2'b00}));

        vc = validCount;
        driveBit(1'b0);
        for (int i = 0; i < 4; i++) driveBit(1'b1);
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        checkOutput("midRstBusy", 32'(Busy), 32'd0);
        checkOutput("midRstDout", 32'(Dout), 32'h00);
        repeat (2 * BIT_CYC) @(posedge CLK);
        #1;
        checkOutput("midRstNoValid", 32'(validCount), 32'(vc));
        applyStimulus(8'h4F, 1'b0, 1'b1, 2);
        checkOutput("afterRstDout", 32'(Dout), 32'h4F);

        applyStimulus(8'h41, 1'b0, 1'b1, 0);
        applyStimulus(8'h42, 1'b0, 1'b1, 2);
        checkLatency("b2bSpacing", lastValidCyc - prevValidCyc, FRAME_BITS * BIT_CYC);
        checkOutput("b2bDout", 32'(Dout), 32'h42);

        checkOutput("validCount", 32'(validCount), 32'(pushCount));
        checkOutput("sbDrained", 32'(sbQ.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
